core_step_controller: RTL and testbench
=======================================

// Module: core_step_controller
// PURPOSE
//  Generates the CPU core enable (core_ena) for the MIPS debug platform. Supports free-run mode,
//  single-step mode (one enable cycle per button press, with dead time), and a PC breakpoint.
//  Sits between the debounced switch/button inputs and the core's ena input.
//  Replaces the one_shot + mux pair.
// PARAMETERS
//  N              32          PC / breakpoint address width
//  DEAD_TIME      50_000_000  cycles a step press is locked out after its pulse (>=1)
//  COUNTER_WIDTH  32          dead-time counter width; must hold DEAD_TIME-1
// PORTS
//  clk          in   1   core clock (cclk); all logic on posedge
//  rst          in   1   synchronous active-high reset
//  step_mode    in   1   1 = single-step, 0 = free run; already debounced
//  step_button  in   1   center button level; async, not debounced
//  bp_ena       in   1   breakpoint enable
//  bp_addr      in   N   breakpoint PC value
//  PC           in   N   current PC from core
//  core_ena     out  1   enable to core
//  step_active  out  1   high while in PULSE or DEAD (drives led[7] with ~step_mode)
//  halted       out  1   high in BREAK state
//  step_count   out  16  number of single-step pulses issued since reset
// BEHAVIOUR
//  Reset: state=IDLE, core_ena=0, step_active=0, halted=0, step_count=0, dead counter=0.
//    btn_q=btn_qq=1, so a button held through reset does not step.
//  Input sync: btn_q<=step_button; btn_qq<=btn_q.
//    press = btn_q & ~btn_qq.
//    Pulse occurs in the cycle after the 2nd posedge following the button rise.
//  States (registered; outputs decoded from state except core_ena in RUN):
//   IDLE:  core_ena=0.
//          step_mode=0 -> RUN.
//          else press -> PULSE.
//   PULSE: core_ena=1 for exactly one cycle; step_count+=1 (wraps 0xFFFF->0).
//          Load counter=DEAD_TIME-1. Next state is always DEAD.
//          Breakpoint is not evaluated in this state.
//   DEAD:  core_ena=0; presses are ignored.
//          Counter decrements each cycle; at 0 -> IDLE.
//          step_mode changes take effect only on return to IDLE.
//   RUN:   core_ena = ~hit, where hit = bp_ena & armed & (PC==bp_addr).
//          hit is combinational, so the core is frozen in the same cycle as the match.
//          hit -> BREAK. step_mode=1 (and no hit) -> IDLE.
//          Presses are ignored.
//   BREAK: core_ena=0, halted=1.
//          press -> PULSE.
//          else step_mode=1 -> IDLE.
//          else bp_ena=0 -> RUN.
//  armed flag:
//   - reset to 1; cleared on entry to BREAK;
//   - set in any cycle where PC!=bp_addr;
//   - ensures that stepping or running out of a breakpoint whose PC is unchanged (multicycle core)
//     does not re-trigger until PC leaves and returns.
//  Simultaneous events in IDLE: step_mode=0 has priority over press.
//  Reset mid-operation: rst dominates in every state; any in-flight pulse or dead time is abandoned.
//  Only the 16-bit step_count wraps; the dead counter never underflows.
// TESTING (DEAD_TIME=4 for all benches)
//  1 rst, step_mode=1, step_button 0->1 -> core_ena=1 for exactly one cycle, 2 posedges after the
//    rise; step_active=1 for 5 cycles; step_count=1.
//  2 Hold button through DEAD, then release; press again after IDLE -> exactly 2 pulses total;
//    step_count=2; presses during DEAD produce no core_ena.
//  3 step_mode=0, bp_ena=1, bp_addr=0x10; PC steps 0x08,0x0C,0x10 -> core_ena low in the cycle
//    PC=0x10; halted=1 next cycle; core_ena stays 0.
//  4 From BREAK with PC held at 0x10: press -> one pulse, then RUN resumes with no re-break.
//    PC 0x14 then 0x10 -> breaks again.
//  5 Assert rst during DEAD (counter=2) -> next cycle all outputs 0, state IDLE, step_count=0.
//    A held button causes no step.
//  6 Preload step_count near wrap via 65536 pulses (or force) -> 0xFFFF then 0x0000; core_ena
//    unaffected.

Source files
------------

// File: rtl/core_step_controller.sv
// Core enable generator for the MIPS debug platform: free-run, single-step with
// dead time after each pulse, and a PC breakpoint that freezes the core on the matching cycle.
module core_step_controller #(
    parameter int N             = 32,
    parameter int DEAD_TIME     = 50_000_000,
    parameter int COUNTER_WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step_mode,
    input  logic         step_button,
    input  logic         bp_ena,
    input  logic [N-1:0] bp_addr,
    input  logic [N-1:0] PC,
    output logic         core_ena,
    output logic         step_active,
    output logic         halted,
    output logic [15:0]  step_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE,
        S_DEAD,
        S_RUN,
        S_BREAK
    } state_t;

    localparam logic [COUNTER_WIDTH-1:0] DEAD_LOAD = COUNTER_WIDTH'(DEAD_TIME - 1);

    state_t                   state;
    state_t                   state_next;
    logic                     btn_q;
    logic                     btn_qq;
    logic                     press;
    logic                     pc_match;
    logic                     armed;
    logic                     hit;
    logic [COUNTER_WIDTH-1:0] dead_cnt;

    assign press    = btn_q & ~btn_qq;
    assign pc_match = (PC == bp_addr);
    assign hit      = bp_ena & armed & pc_match;

    // Both stages reset high so a button already held during reset never
    // looks like a fresh rising edge afterwards.
    // NOTE: state elements use non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours, exactly like the real hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q  <= 1'b1;
            btn_qq <= 1'b1;
        end else begin
            btn_q  <= step_button;
            btn_qq <= btn_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the default assignment ahead of the case keeps this block purely
    // combinational; any path that skipped it would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!step_mode) begin
                    state_next = S_RUN;
                end else if (press) begin
                    state_next = S_PULSE;
                end
            end
            S_PULSE: begin
                state_next = S_DEAD;
            end
            S_DEAD: begin
                if (dead_cnt == '0) begin
                    state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (hit) begin
                    state_next = S_BREAK;
                end else if (step_mode) begin
                    state_next = S_IDLE;
                end
            end
            S_BREAK: begin
                if (press) begin
                    state_next = S_PULSE;
                end else if (step_mode) begin
                    state_next = S_IDLE;
                end else if (!bp_ena) begin
                    state_next = S_RUN;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // In RUN the enable drops combinationally on a hit so the core freezes
    // on the very cycle the PC matches.
    always_comb begin
        core_ena    = 1'b0;
        step_active = 1'b0;
        halted      = 1'b0;
        case (state)
            S_PULSE: begin
                core_ena    = 1'b1;
                step_active = 1'b1;
            end
            S_DEAD: begin
                step_active = 1'b1;
            end
            S_RUN: begin
                core_ena = ~hit;
            end
            S_BREAK: begin
                halted = 1'b1;
            end
            default: begin
                core_ena = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dead_cnt <= '0;
        end else if (state == S_PULSE) begin
            dead_cnt <= DEAD_LOAD;
        end else if (state == S_DEAD && dead_cnt != '0) begin
            dead_cnt <= dead_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_count <= '0;
        end else begin
            step_count <= step_count + 16'(state == S_PULSE);
        end
    end

    // armed blocks a re-trigger while the PC still sits on the breakpoint
    // after leaving BREAK; it rearms once the PC moves elsewhere.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed <= 1'b1;
        end else if (state != S_BREAK && state_next == S_BREAK) begin
            armed <= 1'b0;
        end else if (!pc_match) begin
            armed <= 1'b1;
        end
    end

endmodule

// File: tb/tb_core_step_controller.sv
// Directed bench for core_step_controller with DEAD_TIME=4: stepping, dead-time
// lockout, breakpoint freeze/resume, reset during dead time and step_count wrap.
module tb_core_step_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        step_mode;
    logic        step_button;
    logic        bp_ena;
    logic [31:0] bp_addr;
    logic [31:0] pc;
    logic        core_ena;
    logic        step_active;
    logic        halted;
    logic [15:0] step_count;

    int errors = 0;
    int checks = 0;
    int ena_cnt;
    int act_cnt;
    int first_ena;
    int ena_total;

    core_step_controller #(
        .N(32),
        .DEAD_TIME(4),
        .COUNTER_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .step_mode(step_mode),
        .step_button(step_button),
        .bp_ena(bp_ena),
        .bp_addr(bp_addr),
        .PC(pc),
        .core_ena(core_ena),
        .step_active(step_active),
        .halted(halted),
        .step_count(step_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Raises the button before step 1 and tallies outputs over n cycles;
    // optional drop/re-rise of the button at the given step indices.
    task automatic window(input int n, input int drop_at, input int rise_at,
                          output int e_cnt, output int a_cnt, output int first);
        e_cnt = 0;
        a_cnt = 0;
        first = 0;
        step_button = 1'b1;
        for (int i = 1; i <= n; i++) begin
            if (i == drop_at) step_button = 1'b0;
            if (i == rise_at) step_button = 1'b1;
            step();
            if (core_ena) begin
                e_cnt++;
                if (first == 0) first = i;
            end
            if (step_active) a_cnt++;
        end
    endtask

    initial begin
        rst         = 1'b1;
        step_mode   = 1'b1;
        step_button = 1'b0;
        bp_ena      = 1'b0;
        bp_addr     = 32'h0;
        pc          = 32'h0;

        // Reset state
        step();
        step();
        check("rst_core_ena", {31'd0, core_ena}, 32'd0);
        check("rst_step_active", {31'd0, step_active}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_step_count", {16'd0, step_count}, 32'd0);
        rst = 1'b0;
        step();
        step();
        step();
        check("idle_no_ena", {31'd0, core_ena}, 32'd0);

        // 1: single press, button held afterwards
        window(12, 0, 0, ena_cnt, act_cnt, first_ena);
        check("t1_pulse_count", ena_cnt, 1);
        check("t1_pulse_cycle", first_ena, 2);
        check("t1_active_cycles", act_cnt, 5);
        check("t1_step_count", {16'd0, step_count}, 32'd1);

        // 2: release, press again with a bounce during DEAD
        step_button = 1'b0;
        step();
        step();
        window(12, 4, 5, ena_cnt, act_cnt, first_ena);
        check("t2_pulse_count", ena_cnt, 1);
        check("t2_pulse_cycle", first_ena, 2);
        check("t2_active_cycles", act_cnt, 5);
        check("t2_step_count", {16'd0, step_count}, 32'd2);

        // 3: free run into breakpoint at 0x10
        step_button = 1'b0;
        step_mode   = 1'b0;
        bp_ena      = 1'b1;
        bp_addr     = 32'h10;
        step();
        check("t3_run_ena", {31'd0, core_ena}, 32'd1);
        pc = 32'h08;
        #1;
        check("t3_pc08_ena", {31'd0, core_ena}, 32'd1);
        step();
        pc = 32'h0C;
        #1;
        check("t3_pc0c_ena", {31'd0, core_ena}, 32'd1);
        step();
        pc = 32'h10;
        #1;
        check("t3_hit_ena", {31'd0, core_ena}, 32'd0);
        check("t3_hit_not_halted_yet", {31'd0, halted}, 32'd0);
        step();
        check("t3_halted", {31'd0, halted}, 32'd1);
        check("t3_break_ena", {31'd0, core_ena}, 32'd0);
        step();
        check("t3_break_hold_ena", {31'd0, core_ena}, 32'd0);

        // 4: step out of BREAK with PC parked on the breakpoint
        window(7, 0, 0, ena_cnt, act_cnt, first_ena);
        check("t4_pulse_count", ena_cnt, 1);
        check("t4_pulse_cycle", first_ena, 2);
        check("t4_step_count", {16'd0, step_count}, 32'd3);
        step();
        check("t4_resume_ena", {31'd0, core_ena}, 32'd1);
        check("t4_resume_not_halted", {31'd0, halted}, 32'd0);
        step();
        check("t4_no_rebreak", {31'd0, core_ena}, 32'd1);
        pc = 32'h14;
        step();
        check("t4_pc14_ena", {31'd0, core_ena}, 32'd1);
        pc = 32'h10;
        #1;
        check("t4_rehit_ena", {31'd0, core_ena}, 32'd0);
        step();
        check("t4_rehalted", {31'd0, halted}, 32'd1);

        // 5: reset while DEAD counter is 2, button held through reset
        step_button = 1'b0;
        step_mode   = 1'b1;
        step();
        step();
        check("t5_idle_from_break", {31'd0, halted}, 32'd0);
        step_button = 1'b1;
        step();
        step();
        check("t5_pulse", {31'd0, core_ena}, 32'd1);
        step();
        step();
        check("t5_dead_active", {31'd0, step_active}, 32'd1);
        check("t5_count_before_rst", {16'd0, step_count}, 32'd4);
        rst = 1'b1;
        step();
        check("t5_rst_core_ena", {31'd0, core_ena}, 32'd0);
        check("t5_rst_step_active", {31'd0, step_active}, 32'd0);
        check("t5_rst_halted", {31'd0, halted}, 32'd0);
        check("t5_rst_step_count", {16'd0, step_count}, 32'd0);
        rst = 1'b0;
        ena_total = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (core_ena) ena_total++;
        end
        check("t5_held_button_no_step", ena_total, 0);
        check("t5_idle_inactive", {31'd0, step_active}, 32'd0);

        // 6: step_count wrap, preloaded near the top while idle
        force dut.step_count = 16'hFFFE;
        step();
        release dut.step_count;
        #1;
        check("t6_preload", {16'd0, step_count}, 32'h0000_FFFE);
        step_button = 1'b0;
        step();
        step();
        window(7, 0, 0, ena_cnt, act_cnt, first_ena);
        check("t6_pulse_a", ena_cnt, 1);
        check("t6_count_ffff", {16'd0, step_count}, 32'h0000_FFFF);
        step_button = 1'b0;
        step();
        step();
        window(7, 0, 0, ena_cnt, act_cnt, first_ena);
        check("t6_pulse_b", ena_cnt, 1);
        check("t6_pulse_b_cycle", first_ena, 2);
        check("t6_count_wrap", {16'd0, step_count}, 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
